fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly upstream of the instruction memory and drives its 24-bit byte address (PCAddress).
- Holds the program counter and steps it by 3 bytes per 24-bit instruction.
- Latches the returned big-endian instruction word into the IF/ID pipeline register for decode.
- Handles stall, branch/jump redirect (flush), a halt word and out-of-range fetch faults.

Parameters:
- RESET_VECTOR, 24'h000000, PC value loaded on reset.
- IMEM_BYTES, 64, instruction-memory size in bytes; a fetch is legal only if PC+2 <= IMEM_BYTES-1.
- HALT_WORD, 24'hFFFFFF, instruction encoding that stops fetch.

Ports:
- Clock  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-low reset.
- Stall  input  1  decode/hazard stall; hold PC and IF/ID.
- Redirect  input  1  taken branch/jump; load PC from Target and flush IF/ID.
- Target  input  24  redirect byte address.
- Instruction  input  24  word returned combinationally by instruction memory for PCAddress.
- PCAddress  output  24  current PC, driven combinationally from the PC register.
- IFIDInstruction  output  24  latched instruction.
- IFIDPC  output  24  byte address of the latched instruction.
- IFIDValid  output  1  IF/ID holds a real instruction.
- Halted  output  1  state == HALTED.
- Fault  output  1  state == FAULT.

Behaviour:
- Reset (Reset=0, asynchronous):
  - PC=RESET_VECTOR.
  - IFIDInstruction=0, IFIDPC=0, IFIDValid=0.
  - State=RUN; Halted=0, Fault=0.
  - Reset asserted mid-operation discards all state immediately.
- Latency: PCAddress=PC in the same cycle. The instruction at PC appears on IF/ID after the next rising edge (1 cycle).
- States: RUN, HALTED, FAULT. Per-edge priority: Redirect > Stall > state action.
- Redirect=1, any state:
  - PC<=Target; IFIDValid<=0; state<=RUN.
  - Overrides a simultaneous Stall, so a speculatively fetched halt or fault is cancelled.
  - Target is not checked for 3-byte alignment; range is checked on the next fetch.
- Stall=1 and Redirect=0: PC, IF/ID registers and state all hold.
- RUN, no stall/redirect:
  - If PC+2 > IMEM_BYTES-1, computed in 25 bits so no wrap: state<=FAULT, IFIDValid<=0, PC holds.
  - Else if Instruction==HALT_WORD: IFIDInstruction<=Instruction, IFIDPC<=PC, IFIDValid<=1, PC holds, state<=HALTED. The halt word itself is delivered to decode.
  - Else: IFIDInstruction<=Instruction, IFIDPC<=PC, IFIDValid<=1, PC<=PC+3 (mod 2^24).
- HALTED, no stall/redirect: IFIDValid<=0, PC holds. Exit only via Redirect or Reset.
- FAULT, no stall/redirect: IFIDValid<=0, PC holds. Exit only via Redirect or Reset.
- IFIDInstruction and IFIDPC are not cleared on flush or bubble; only IFIDValid is cleared.
- Exactly one flop stage (no skid buffer); Instruction is sampled only on the capturing edge.

Test Plan:
- Sequential fetch: reset with memory bytes 0..8 = 01 02 03 04 05 06 07 08 09, release.
  -> PCAddress=0, then 3, then 6 on successive edges.
  -> IF/ID reads 010203@PC0, then 040506@PC3, then 070809@PC6, IFIDValid=1 each time.
- Stall: assert Stall for 2 cycles while PC=6.
  -> PCAddress stays 6; IF/ID holds 040506/3/valid.
  -> After release, next edge latches 070809@PC6.
- Redirect vs stall: at PC=9 drive Redirect=1, Stall=1, Target=24'h00001E.
  -> Next edge: PCAddress=0x1E, IFIDValid=0.
  -> Following edge: IF/ID holds the word at 0x1E with IFIDPC=0x1E.
- Halt: place FFFFFF at byte 12.
  -> Edge at PC=12: IF/ID=FFFFFF/12/valid, Halted=1, PCAddress stays 12.
  -> Next edge: IFIDValid=0.
  -> Redirect to 0: Halted=0, fetch resumes at 0.
- Out-of-range: Redirect Target=62 (IMEM_BYTES=64).
  -> Next edge: Fault=1, IFIDValid=0, PCAddress=62.
  -> Target=61 instead is legal: fetches bytes 61..63.
- Async reset mid-run: pull Reset low between edges at PC=15.
  -> Immediately PCAddress=0, IFIDValid=0, Halted=0, Fault=0, with no clock edge needed.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the program counter, presents it to the
// instruction memory and captures the returned 24-bit word into the IF/ID
// pipeline register. Handles stalls, redirects (flush), a halt word and
// fetches that would run past the end of instruction memory.
module fetch_stage #(
    parameter logic [23:0] RESET_VECTOR = 24'h000000,
    parameter int          IMEM_BYTES   = 64,
    parameter logic [23:0] HALT_WORD    = 24'hFFFFFF
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [23:0] Target,
    input  logic [23:0] Instruction,
    output logic [23:0] PCAddress,
    output logic [23:0] IFIDInstruction,
    output logic [23:0] IFIDPC,
    output logic        IFIDValid,
    output logic        Halted,
    output logic        Fault
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HALTED = 2'd1,
        FAULT  = 2'd2
    } state_t;

    // Highest legal byte address, widened so PC+2 can never wrap around.
    localparam logic [24:0] LAST_BYTE = 25'(IMEM_BYTES - 1);

    state_t      state_reg;
    logic [23:0] pc_reg;
    logic [23:0] ifid_instr_reg;
    logic [23:0] ifid_pc_reg;
    logic        ifid_valid_reg;
    logic        halted_reg;
    logic        fault_reg;
    logic        fetch_in_range;

    // The last byte of a 3-byte instruction must still lie inside memory.
    always_comb begin
        fetch_in_range = ({1'b0, pc_reg} + 25'd2) <= LAST_BYTE;
    end

    // PC, IF/ID register and fetch state machine; Redirect beats Stall,
    // Stall beats the per-state action.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_VECTOR;
            ifid_instr_reg <= 24'h000000;
            ifid_pc_reg    <= 24'h000000;
            ifid_valid_reg <= 1'b0;
            halted_reg     <= 1'b0;
            fault_reg      <= 1'b0;
        end else if (Redirect) begin
            // Flush: anything fetched speculatively (including a halt or a
            // fault) is cancelled. Alignment is not checked; range is
            // checked when the new PC is actually fetched.
            pc_reg         <= Target;
            ifid_valid_reg <= 1'b0;
            state_reg      <= RUN;
            halted_reg     <= 1'b0;
            fault_reg      <= 1'b0;
        end else if (!Stall) begin
            case (state_reg)
                RUN: begin
                    if (!fetch_in_range) begin
                        state_reg      <= FAULT;
                        fault_reg      <= 1'b1;
                        ifid_valid_reg <= 1'b0;
                    end else if (Instruction == HALT_WORD) begin
                        // The halt word is still handed to decode, but the
                        // PC parks on it.
                        ifid_instr_reg <= Instruction;
                        ifid_pc_reg    <= pc_reg;
                        ifid_valid_reg <= 1'b1;
                        state_reg      <= HALTED;
                        halted_reg     <= 1'b1;
                    end else begin
                        ifid_instr_reg <= Instruction;
                        ifid_pc_reg    <= pc_reg;
                        ifid_valid_reg <= 1'b1;
                        pc_reg         <= pc_reg + 24'd3;
                    end
                end
                HALTED, FAULT: begin
                    // Parked: emit bubbles until redirected or reset.
                    ifid_valid_reg <= 1'b0;
                end
                default: begin
                    // Unreachable encoding: park safely in FAULT.
                    ifid_valid_reg <= 1'b0;
                    state_reg      <= FAULT;
                    halted_reg     <= 1'b0;
                    fault_reg      <= 1'b1;
                end
            endcase
        end
    end

    // Outputs come straight from registers.
    always_comb begin
        PCAddress       = pc_reg;
        IFIDInstruction = ifid_instr_reg;
        IFIDPC          = ifid_pc_reg;
        IFIDValid       = ifid_valid_reg;
        Halted          = halted_reg;
        Fault           = fault_reg;
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a 64-byte instruction memory model, a table of
// per-edge stimulus with hand-derived expectations fed through a scoreboard
// queue, plus hand-written reset sequences.
module tb_fetch_stage;

    logic        Clock;
    logic        Reset;
    logic        Stall;
    logic        Redirect;
    logic [23:0] Target;
    logic [23:0] Instruction;
    logic [23:0] PCAddress;
    logic [23:0] IFIDInstruction;
    logic [23:0] IFIDPC;
    logic        IFIDValid;
    logic        Halted;
    logic        Fault;

    fetch_stage #(
        .RESET_VECTOR(24'h000000),
        .IMEM_BYTES  (64),
        .HALT_WORD   (24'hFFFFFF)
    ) dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .Stall          (Stall),
        .Redirect       (Redirect),
        .Target         (Target),
        .Instruction    (Instruction),
        .PCAddress      (PCAddress),
        .IFIDInstruction(IFIDInstruction),
        .IFIDPC         (IFIDPC),
        .IFIDValid      (IFIDValid),
        .Halted         (Halted),
        .Fault          (Fault)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Big-endian combinational instruction memory; out-of-range reads give 0.
    logic [7:0] mem [64];
    logic [5:0] mem_addr;
    assign mem_addr    = PCAddress[5:0];
    assign Instruction = (PCAddress <= 24'd61)
                       ? {mem[mem_addr], mem[mem_addr + 6'd1], mem[mem_addr + 6'd2]}
                       : 24'h000000;

    typedef struct {
        logic        stall;
        logic        redir;
        logic [23:0] target;
        logic [23:0] pc;
        logic [23:0] instr;
        logic [23:0] ipc;
        logic        valid;
        logic        halted;
        logic        fault;
    } vec_t;

    localparam int NVEC = 21;
    vec_t vecs [NVEC];
    vec_t exp_q [$];

    int checks;
    int failures;

    task automatic check(input string name, input int row,
                         input logic [23:0] got, input logic [23:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s row=%0d got=%h want=%h", name, row, got, want);
        end
    endtask

    function automatic vec_t mk(input logic s, input logic r, input logic [23:0] t,
                                input logic [23:0] pc, input logic [23:0] in,
                                input logic [23:0] ipc, input logic v,
                                input logic h, input logic f);
        vec_t x;
        x.stall = s; x.redir = r; x.target = t; x.pc = pc; x.instr = in;
        x.ipc = ipc; x.valid = v; x.halted = h; x.fault = f;
        return x;
    endfunction

    // Compare all outputs against the oldest queued expectation.
    task automatic score(input int row);
        vec_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_empty row=%0d got=0 want=1", row);
        end else begin
            e = exp_q.pop_front();
            check("pc",     row, PCAddress,       e.pc);
            check("instr",  row, IFIDInstruction, e.instr);
            check("ifidpc", row, IFIDPC,          e.ipc);
            check("valid",  row, {23'd0, IFIDValid}, {23'd0, e.valid});
            check("halted", row, {23'd0, Halted},    {23'd0, e.halted});
            check("fault",  row, {23'd0, Fault},     {23'd0, e.fault});
            $display("row %0d stall=%0b redir=%0b tgt=%h -> pc=%h ifid=%h@%h v=%0b h=%0b f=%0b",
                     row, e.stall, e.redir, e.target, PCAddress, IFIDInstruction,
                     IFIDPC, IFIDValid, Halted, Fault);
        end
    endtask

    // Drive one edge's worth of inputs, queue the expectation, sample after.
    task automatic step(input vec_t v, input int row);
        Stall    = v.stall;
        Redirect = v.redir;
        Target   = v.target;
        exp_q.push_back(v);
        @(posedge Clock);
        #1;
        score(row);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        for (int i = 0; i < 12; i++) mem[i] = 8'(i + 1);
        mem[12] = 8'hFF; mem[13] = 8'hFF; mem[14] = 8'hFF;
        mem[30] = 8'hAA; mem[31] = 8'hBB; mem[32] = 8'hCC;
        mem[61] = 8'h3D; mem[62] = 8'h3E; mem[63] = 8'h3F;

        //           stall redir target      pc        instr       ipc     v  h  f
        vecs[0]  = mk(0, 0, 24'h0,  24'h03, 24'h010203, 24'h00, 1, 0, 0);
        vecs[1]  = mk(0, 0, 24'h0,  24'h06, 24'h040506, 24'h03, 1, 0, 0);
        vecs[2]  = mk(1, 0, 24'h0,  24'h06, 24'h040506, 24'h03, 1, 0, 0);
        vecs[3]  = mk(1, 0, 24'h0,  24'h06, 24'h040506, 24'h03, 1, 0, 0);
        vecs[4]  = mk(0, 0, 24'h0,  24'h09, 24'h070809, 24'h06, 1, 0, 0);
        vecs[5]  = mk(1, 1, 24'h1E, 24'h1E, 24'h070809, 24'h06, 0, 0, 0);
        vecs[6]  = mk(0, 0, 24'h0,  24'h21, 24'hAABBCC, 24'h1E, 1, 0, 0);
        vecs[7]  = mk(0, 1, 24'h0C, 24'h0C, 24'hAABBCC, 24'h1E, 0, 0, 0);
        vecs[8]  = mk(1, 0, 24'h0,  24'h0C, 24'hAABBCC, 24'h1E, 0, 0, 0);
        vecs[9]  = mk(0, 0, 24'h0,  24'h0C, 24'hFFFFFF, 24'h0C, 1, 1, 0);
        vecs[10] = mk(0, 0, 24'h0,  24'h0C, 24'hFFFFFF, 24'h0C, 0, 1, 0);
        vecs[11] = mk(1, 0, 24'h0,  24'h0C, 24'hFFFFFF, 24'h0C, 0, 1, 0);
        vecs[12] = mk(0, 1, 24'h0,  24'h00, 24'hFFFFFF, 24'h0C, 0, 0, 0);
        vecs[13] = mk(0, 0, 24'h0,  24'h03, 24'h010203, 24'h00, 1, 0, 0);
        vecs[14] = mk(0, 1, 24'h3E, 24'h3E, 24'h010203, 24'h00, 0, 0, 0);
        vecs[15] = mk(0, 0, 24'h0,  24'h3E, 24'h010203, 24'h00, 0, 0, 1);
        vecs[16] = mk(0, 0, 24'h0,  24'h3E, 24'h010203, 24'h00, 0, 0, 1);
        vecs[17] = mk(0, 1, 24'h3D, 24'h3D, 24'h010203, 24'h00, 0, 0, 0);
        vecs[18] = mk(0, 0, 24'h0,  24'h40, 24'h3D3E3F, 24'h3D, 1, 0, 0);
        vecs[19] = mk(0, 0, 24'h0,  24'h40, 24'h3D3E3F, 24'h3D, 0, 0, 1);
        vecs[20] = mk(1, 1, 24'h0F, 24'h0F, 24'h3D3E3F, 24'h3D, 0, 0, 0);

        // Reset state, held across a couple of edges.
        Reset = 1'b0; Stall = 1'b0; Redirect = 1'b0; Target = 24'h0;
        repeat (2) @(posedge Clock);
        #1;
        exp_q.push_back(mk(0, 0, 24'h0, 24'h00, 24'h000000, 24'h00, 0, 0, 0));
        score(-1);
        Reset = 1'b1;
        #1;
        exp_q.push_back(mk(0, 0, 24'h0, 24'h00, 24'h000000, 24'h00, 0, 0, 0));
        score(-2);

        for (int i = 0; i < NVEC; i++) step(vecs[i], i);

        // Asynchronous reset between edges while sitting at PC=0x0F with a
        // valid-looking IF/ID history: must clear with no clock edge.
        #2;
        Reset = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 24'h0, 24'h00, 24'h000000, 24'h00, 0, 0, 0));
        score(100);

        // Release and confirm fetch restarts from the reset vector.
        @(negedge Clock);
        Reset = 1'b1;
        step(mk(0, 0, 24'h0, 24'h03, 24'h010203, 24'h00, 1, 0, 0), 101);

        // Async reset while faulted must also clear Fault immediately.
        step(mk(0, 1, 24'h3F, 24'h3F, 24'h010203, 24'h00, 0, 0, 0), 102);
        step(mk(0, 0, 24'h0,  24'h3F, 24'h010203, 24'h00, 0, 0, 1), 103);
        #2;
        Reset = 1'b0;
        #1;
        exp_q.push_back(mk(0, 0, 24'h0, 24'h00, 24'h000000, 24'h00, 0, 0, 0));
        score(104);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
